// File: rtl/cpu_defs.sv
// Shared encodings for the simple-RISC controller: states, instruction classes,
// opcode/op fields and datapath select one-hots.
package cpu_defs;

  typedef enum logic [3:0] {
    ST_WAIT    = 4'd0,
    ST_DECODE  = 4'd1,
    ST_WR_IMM  = 4'd2,
    ST_GET_A   = 4'd3,
    ST_GET_B   = 4'd4,
    ST_EXEC    = 4'd5,
    ST_CMP     = 4'd6,
    ST_WR_REG  = 4'd7,
    ST_BAD     = 4'd8
  } state_t;

  typedef enum logic [1:0] {
    CLS_MOVIMM = 2'd0,
    CLS_MOVREG = 2'd1,
    CLS_ALU    = 2'd2,
    CLS_CMP    = 2'd3
  } cls_t;

  typedef struct packed {
    logic valid;
    cls_t cls;
  } dec_t;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MOVIMM  = 2'b10;
  localparam logic [1:0] OP_MOVREG  = 2'b00;

  localparam logic [2:0] NSEL_NONE  = 3'b000;
  localparam logic [2:0] NSEL_RN    = 3'b001;
  localparam logic [2:0] NSEL_RD    = 3'b010;
  localparam logic [2:0] NSEL_RM    = 3'b100;
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;

  // Every ALU op is a legal class, so only MOV has holes in its op field.
  function automatic dec_t decode_instr(input logic [2:0] opcode, input logic [1:0] op);
    dec_t d;
    d.valid = 1'b0;
    d.cls   = CLS_MOVIMM;
    if (opcode == OPC_MOV && op == OP_MOVIMM) begin
      d.valid = 1'b1;
      d.cls   = CLS_MOVIMM;
    end else if (opcode == OPC_MOV && op == OP_MOVREG) begin
      d.valid = 1'b1;
      d.cls   = CLS_MOVREG;
    end else if (opcode == OPC_ALU && op == OP_CMP) begin
      d.valid = 1'b1;
      d.cls   = CLS_CMP;
    end else if (opcode == OPC_ALU) begin
      d.valid = 1'b1;
      d.cls   = CLS_ALU;
    end
    return d;
  endfunction

endpackage

// File: rtl/cpu_fsm.sv
// Moore controller sequencing the datapath for one instruction per `s` request.
// Outputs decode from the state register and the class latched in DECODE.
module cpu_fsm
  import cpu_defs::*;
#(
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       write,
  output logic       w,
  output logic       bad_op
);

  state_t r_state;
  state_t w_next;
  cls_t   r_cls;
  dec_t   w_dec;

  assign w_dec = decode_instr(opcode, op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_WAIT;
      r_cls   <= CLS_MOVIMM;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) r_cls <= w_dec.cls;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT:   if (s) w_next = ST_DECODE;
      ST_DECODE: begin
        if (!w_dec.valid)                w_next = STRICT_DECODE ? ST_BAD : ST_WAIT;
        else if (w_dec.cls == CLS_MOVIMM) w_next = ST_WR_IMM;
        else if (w_dec.cls == CLS_MOVREG) w_next = ST_GET_B;
        else                              w_next = ST_GET_A;
      end
      ST_WR_IMM: w_next = ST_WAIT;
      ST_GET_A:  w_next = ST_GET_B;
      ST_GET_B:  w_next = (r_cls == CLS_CMP) ? ST_CMP : ST_EXEC;
      ST_EXEC:   w_next = ST_WR_REG;
      ST_CMP:    w_next = ST_WAIT;
      ST_WR_REG: w_next = ST_WAIT;
      ST_BAD:    w_next = ST_WAIT;
      default:   w_next = ST_WAIT;
    endcase
  end

  always_comb begin
    nsel   = NSEL_NONE;
    vsel   = VSEL_C;
    loada  = 1'b0;
    loadb  = 1'b0;
    asel   = 1'b0;
    bsel   = 1'b0;
    loadc  = 1'b0;
    loads  = 1'b0;
    write  = 1'b0;
    w      = 1'b0;
    bad_op = 1'b0;
    case (r_state)
      ST_WAIT:   w = 1'b1;
      ST_WR_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      ST_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      ST_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      ST_EXEC: begin
        loadc = 1'b1;
        asel  = (r_cls == CLS_MOVREG);
      end
      ST_CMP:    loads = 1'b1;
      ST_WR_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      ST_BAD:    bad_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/cpu_fsm.md
Name: cpu_fsm

Overview:
- Moore controller that sequences the simple-RISC datapath (regfile R0–R7, A/B/C registers, shifter, ALU, status register) for each instruction held in the instruction register.
- Starts an instruction on `s`, drives register select, load enables and writeback muxing, and raises `w` when idle.
- Sits inside `cpu`, between the instruction decoder and the datapath.

Parameters:
- STRICT_DECODE, 1, 1: unsupported opcode/op goes to state BAD and pulses `bad_op`. 0: treated as a NOP that returns to WAIT with no writes.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; forces WAIT
- s  input  1  start request, level-sampled in WAIT only
- opcode  input  3  IR[15:13]
- op  input  2  IR[12:11]
- nsel  output  3  one-hot regfile read/write select: 001=Rn IR[10:8], 010=Rd IR[7:5], 100=Rm IR[2:0]; 000 when unused
- vsel  output  2  writeback source: 00=C, 01=sximm8, 1x reserved (never driven)
- loada  output  1  load A register from regfile
- loadb  output  1  load B register from regfile
- asel  output  1  1 = ALU A operand forced to 0
- bsel  output  1  1 = sximm5 on B; always 0 in this ISA subset
- loadc  output  1  load C from ALU result
- loads  output  1  load N/V/Z status from ALU
- write  output  1  regfile write enable
- w  output  1  1 only in state WAIT
- bad_op  output  1  1 only in state BAD

Behaviour:
- States: WAIT, DECODE, WR_IMM, GET_A, GET_B, EXEC, CMP, WR_REG, BAD. State is registered; all outputs decode from state only (Moore).
- Outputs not listed for a state are 0.
- Reset is asynchronous to WAIT: `w`=1 and every other output 0, including when reset is applied mid-instruction. No partial write completes after reset.
- WAIT: `w`=1. If `s`=1 at a posedge, go to DECODE; otherwise stay.
- DECODE: sample `{opcode, op}` and latch a 2-bit class register. Later changes on opcode/op are ignored until the next DECODE.
  - 110_10 (MOV Rn,#imm8) → WR_IMM.
  - 110_00 (MOV Rd,Rm{,sh}) → GET_B.
  - 101_00 ADD, 101_10 AND, 101_11 MVN → GET_A.
  - 101_01 CMP → GET_A.
  - Anything else → BAD if STRICT_DECODE, else WAIT.
- WR_IMM: nsel=001, vsel=01, write=1 → WAIT.
- GET_A: nsel=001, loada=1 → GET_B.
- GET_B: nsel=100, loadb=1 → CMP if class=CMP, else EXEC.
- EXEC: loadc=1; asel=1 only for class MOV-reg → WR_REG.
- CMP: loads=1, loadc=0 → WAIT. No regfile write.
- WR_REG: nsel=010, vsel=00, write=1 → WAIT.
- BAD: bad_op=1 → WAIT.
- ALU ops and MOV do not update status; only CMP sets `loads`.
- Shift and ALU-op fields go to the datapath directly; the controller does not decode them.
- `w`-low duration per instruction:
  - MOV imm: 2 cycles
  - MOV reg: 4 cycles
  - CMP: 4 cycles
  - ADD/AND/MVN: 5 cycles
  - BAD: 2 cycles
- `s` held high across completion: a new instruction starts on the first posedge in WAIT, so `w` is high for exactly 1 cycle.
- `s` pulses while busy are ignored; they are not queued.
- At most one of loada/loadb/loadc/loads/write is high in any cycle. nsel is nonzero only when loada, loadb or write is 1.

Decomposition:
- Shared package `cpu_defs`:
  - State encoding enum (4-bit).
  - Opcode/op localparams: OPC_MOV=3'b110, OPC_ALU=3'b101, OP_ADD/CMP/AND/MVN, OP_MOVIMM=2'b10, OP_MOVREG=2'b00.
  - NSEL_RN/RD/RM one-hots; VSEL_C/VSEL_IMM.
- Single module; no sub-module. The next-state block and output decode are separate always blocks.

Test Plan:
- Reset, then `s`=1 with 110_10: `w` 1→0 for 2 cycles; WR_IMM cycle shows nsel=001, vsel=01, write=1; `w` returns 1.
- ADD (101_00): `w` low 5 cycles; observed sequence loada(nsel=001) → loadb(nsel=100) → loadc(asel=0) → write(nsel=010, vsel=00); loads never 1.
- CMP (101_01): `w` low 4 cycles; loads=1 exactly one cycle, write never 1. MOV reg (110_00): asel=1 in EXEC, loada never 1.
- opcode=3'b111, STRICT_DECODE=1: bad_op=1 for one cycle, no load/write, `w` low 2 cycles. Same stimulus with STRICT_DECODE=0: `w` low 1 cycle, bad_op stays 0.
- Assert reset during GET_B of an ADD: next sample shows `w`=1 and all enables 0; write never asserts. After release and `s`, MOV imm completes normally.
- `s` held high across two back-to-back MOV imm: `w` high exactly 1 cycle between them. Change opcode mid-ADD: sequence unchanged.
